trap_sequencer: RTL and testbench

- Multi-cycle controller that sequences trap entry and xRET exit for the privileged datapath.
- Takes the exception/cause/trap_PC/xRET outputs of the privilege-check logic at memory-receive, plus pending interrupts.
- Arbitrates between them, flushes and stalls the pipeline, and writes the trap CSRs one at a time through the single CSR write port.
- Updates the privilege mode, then issues a single PC redirect to the trap vector or return address.

---
 rtl/priv_pkg.sv | 33 +++
 rtl/trap_target_select.sv | 33 +++
 rtl/trap_sequencer.sv | 171 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/priv_pkg.sv
// priv_pkg: privilege modes, trap CSR addresses, sequencer states and mstatus field positions.
package priv_pkg;
    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_S = 2'b01;
    localparam logic [1:0] MODE_M = 2'b11;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SAVE_TVAL,
        ST_UPDATE_STATUS,
        ST_REDIRECT
    } state_t;
endpackage

// File: rtl/trap_target_select.sv
// trap_target_select: delegation decision and redirect target for an accepted trap or xRET.
module trap_target_select
    import priv_pkg::*;
#(
    parameter int ADDRESS_BITS = 20
) (
    input  logic [1:0]              priv,
    input  logic                    is_intr,
    input  logic                    is_ret,
    input  logic                    ret_s,
    input  logic [3:0]              code,
    input  logic [15:0]             medeleg,
    input  logic [15:0]             mideleg,
    input  logic [ADDRESS_BITS-1:0] mtvec,
    input  logic [ADDRESS_BITS-1:0] stvec,
    input  logic [ADDRESS_BITS-1:0] mepc,
    input  logic [ADDRESS_BITS-1:0] sepc,
    output logic                    to_s,
    output logic [ADDRESS_BITS-1:0] target
);
    logic                    deleg;
    logic [ADDRESS_BITS-1:0] tvec;
    logic [ADDRESS_BITS-1:0] base;

    assign deleg = (priv != MODE_M) && (is_intr ? mideleg[code] : medeleg[code]);
    assign to_s  = is_ret ? ret_s : deleg;
    assign tvec  = to_s ? stvec : mtvec;
    assign base  = {tvec[ADDRESS_BITS-1:2], 2'b00};
    // Vectored mode only offsets interrupts; the add wraps at ADDRESS_BITS.
    assign target = is_ret ? (ret_s ? sepc : mepc)
                  : (tvec[1:0] == 2'b01 && is_intr) ? base + ADDRESS_BITS'({code, 2'b00})
                  : base;
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences trap entry and xRET exit, writing trap CSRs one per cycle
// and finishing with a single PC redirect and privilege update.
module trap_sequencer
    import priv_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    exception,
    input  logic [3:0]              exception_code,
    input  logic                    intr_pending,
    input  logic [3:0]              intr_code,
    input  logic [ADDRESS_BITS-1:0] trap_PC,
    input  logic [DATA_WIDTH-1:0]   trap_value,
    input  logic                    m_ret,
    input  logic                    s_ret,
    input  logic [DATA_WIDTH-1:0]   mstatus,
    input  logic [15:0]             medeleg,
    input  logic [15:0]             mideleg,
    input  logic [ADDRESS_BITS-1:0] mtvec,
    input  logic [ADDRESS_BITS-1:0] stvec,
    input  logic [ADDRESS_BITS-1:0] mepc,
    input  logic [ADDRESS_BITS-1:0] sepc,
    output logic                    csr_wr_en,
    output logic [11:0]             csr_wr_addr,
    output logic [DATA_WIDTH-1:0]   csr_wr_data,
    output logic                    flush,
    output logic                    stall,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic [1:0]              priv,
    output logic                    busy,
    input  logic                    scan
);
    state_t                  state, state_n;
    logic                    is_ret_q, to_s_q;
    logic [DATA_WIDTH-1:0]   cause_q, tval_q, status_new;
    logic [ADDRESS_BITS-1:0] epc_q, tgt_q, sel_pc;
    logic [1:0]              priv_new_q, priv_upd;
    logic                    accept, acc_intr, acc_ret, acc_sret, sel_s;
    logic [3:0]              acc_code;
    logic                    unused_scan;

    assign unused_scan = ^{scan, (CORE != 0), (SCAN_CYCLES_MIN > SCAN_CYCLES_MAX)};

    // Priority exception > interrupt > MRET > SRET; losers are simply dropped.
    assign accept   = (state == ST_IDLE) && (exception || intr_pending || m_ret || s_ret);
    assign acc_intr = !exception && intr_pending;
    assign acc_ret  = !exception && !intr_pending && (m_ret || s_ret);
    assign acc_sret = acc_ret && !m_ret;
    assign acc_code = exception ? exception_code : intr_code;
    assign busy     = (state != ST_IDLE);
    assign stall    = busy;

    trap_target_select #(.ADDRESS_BITS(ADDRESS_BITS)) u_target (
        .priv    (priv),
        .is_intr (acc_intr),
        .is_ret  (acc_ret),
        .ret_s   (acc_sret),
        .code    (acc_code),
        .medeleg (medeleg),
        .mideleg (mideleg),
        .mtvec   (mtvec),
        .stvec   (stvec),
        .mepc    (mepc),
        .sepc    (sepc),
        .to_s    (sel_s),
        .target  (sel_pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            priv       <= MODE_M;
            is_ret_q   <= 1'b0;
            to_s_q     <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            tgt_q      <= '0;
            priv_new_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                is_ret_q <= acc_ret;
                to_s_q   <= sel_s;
                cause_q  <= {acc_intr, {(DATA_WIDTH-5){1'b0}}, acc_code};
                epc_q    <= trap_PC;
                tval_q   <= acc_intr ? '0 : trap_value;
                tgt_q    <= sel_pc;
            end
            if (state == ST_UPDATE_STATUS) priv_new_q <= priv_upd;
            if (state == ST_REDIRECT) priv <= priv_new_q;
        end
    end

    always_comb begin
        state_n        = state;
        flush          = 1'b0;
        csr_wr_en      = 1'b0;
        csr_wr_addr    = '0;
        csr_wr_data    = '0;
        redirect_valid = 1'b0;
        redirect_PC    = '0;
        status_new     = mstatus;
        priv_upd       = priv;
        if (is_ret_q && !to_s_q) begin
            status_new[MS_MIE]              = mstatus[MS_MPIE];
            status_new[MS_MPIE]             = 1'b1;
            status_new[MS_MPP_HI:MS_MPP_LO] = MODE_U;
            priv_upd                        = mstatus[MS_MPP_HI:MS_MPP_LO];
        end else if (is_ret_q) begin
            status_new[MS_SIE]  = mstatus[MS_SPIE];
            status_new[MS_SPIE] = 1'b1;
            status_new[MS_SPP]  = 1'b0;
            priv_upd            = {1'b0, mstatus[MS_SPP]};
        end else if (to_s_q) begin
            status_new[MS_SPIE] = mstatus[MS_SIE];
            status_new[MS_SIE]  = 1'b0;
            status_new[MS_SPP]  = priv[0];
            priv_upd            = MODE_S;
        end else begin
            status_new[MS_MPIE]             = mstatus[MS_MIE];
            status_new[MS_MIE]              = 1'b0;
            status_new[MS_MPP_HI:MS_MPP_LO] = priv;
            priv_upd                        = MODE_M;
        end
        case (state)
            ST_IDLE: state_n = accept ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: begin
                flush   = 1'b1;
                state_n = is_ret_q ? ST_UPDATE_STATUS : ST_SAVE_EPC;
            end
            ST_SAVE_EPC: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = to_s_q ? CSR_SEPC : CSR_MEPC;
                csr_wr_data = DATA_WIDTH'(epc_q);
                state_n     = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = to_s_q ? CSR_SCAUSE : CSR_MCAUSE;
                csr_wr_data = cause_q;
                state_n     = ST_SAVE_TVAL;
            end
            ST_SAVE_TVAL: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = to_s_q ? CSR_STVAL : CSR_MTVAL;
                csr_wr_data = tval_q;
                state_n     = ST_UPDATE_STATUS;
            end
            ST_UPDATE_STATUS: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = to_s_q ? CSR_SSTATUS : CSR_MSTATUS;
                csr_wr_data = status_new;
                state_n     = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_PC    = tgt_q;
                state_n        = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed cycle-by-cycle checks of trap entry, xRET exit, arbitration and reset abort.
module tb_trap_sequencer;
    logic        clock = 0, reset = 0;
    logic        exception = 0, intr_pending = 0, m_ret = 0, s_ret = 0, scan = 0;
    logic [3:0]  exception_code = 0, intr_code = 0;
    logic [19:0] trap_PC = 0, mtvec = 0, stvec = 0, mepc = 0, sepc = 0;
    logic [31:0] trap_value = 0, mstatus = 0;
    logic [15:0] medeleg = 0, mideleg = 0;
    logic        csr_wr_en, flush, stall, redirect_valid, busy;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [19:0] redirect_PC;
    logic [1:0]  priv;
    int          errors = 0, checks = 0;

    trap_sequencer dut (
        .clock(clock), .reset(reset), .exception(exception), .exception_code(exception_code),
        .intr_pending(intr_pending), .intr_code(intr_code), .trap_PC(trap_PC),
        .trap_value(trap_value), .m_ret(m_ret), .s_ret(s_ret), .mstatus(mstatus),
        .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr),
        .csr_wr_data(csr_wr_data), .flush(flush), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_PC(redirect_PC), .priv(priv),
        .busy(busy), .scan(scan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Check one busy cycle's outputs, then advance to the next cycle.
    task automatic step(input string tag, input logic en, input logic [11:0] addr,
                        input logic [31:0] data, input logic fl, input logic rv,
                        input logic [19:0] rpc);
        check({tag, ".ctl"}, 32'({busy, stall, flush, csr_wr_en, redirect_valid}),
              32'({2'b11, fl, en, rv}));
        if (en) begin
            check({tag, ".addr"}, 32'(csr_wr_addr), 32'(addr));
            check({tag, ".data"}, csr_wr_data, data);
        end
        if (rv) check({tag, ".pc"}, 32'(redirect_PC), 32'(rpc));
        tick();
    endtask

    task automatic trap_seq(input string tag, input logic s, input logic [19:0] epc,
                            input logic [31:0] cause, input logic [31:0] tval,
                            input logic [31:0] status, input logic [19:0] rpc, input logic inject);
        logic [11:0] b;
        b = s ? 12'h100 : 12'h300;
        step({tag, ".flush"}, 0, 0, 0, 1, 0, 0);
        step({tag, ".epc"}, 1, b + 12'h41, {12'b0, epc}, 0, 0, 0);
        if (inject) begin
            exception = 1; exception_code = 4'h3; trap_PC = 20'h999; trap_value = 32'h1;
        end
        step({tag, ".cause"}, 1, b + 12'h42, cause, 0, 0, 0);
        exception = 0;
        step({tag, ".tval"}, 1, b + 12'h43, tval, 0, 0, 0);
        step({tag, ".status"}, 1, b, status, 0, 0, 0);
        step({tag, ".redir"}, 0, 0, 0, 0, 1, rpc);
    endtask

    task automatic ret_seq(input string tag, input logic s, input logic [31:0] status,
                           input logic [19:0] rpc);
        step({tag, ".flush"}, 0, 0, 0, 1, 0, 0);
        step({tag, ".status"}, 1, s ? 12'h100 : 12'h300, status, 0, 0, 0);
        step({tag, ".redir"}, 0, 0, 0, 0, 1, rpc);
    endtask

    initial begin
        tick(); tick();
        check("rst.ctl", 32'({busy, stall, flush, csr_wr_en, redirect_valid}), 0);
        check("rst.priv", 32'(priv), 3);
        reset = 1;
        tick();

        // MRET from M with MPP=S, MPIE=1
        mstatus = 32'h880; mepc = 20'h80; m_ret = 1;
        tick(); m_ret = 0;
        ret_seq("mret", 0, 32'h88, 20'h80);
        check("mret.priv", 32'(priv), 1);
        check("mret.idle", 32'(busy), 0);

        // delegated vectored interrupt in S
        mideleg = 16'h0020; stvec = 20'h201; mtvec = 20'h400; intr_code = 4'd5;
        trap_PC = 20'h1234; trap_value = 32'h5555; mstatus = 32'h2; intr_pending = 1;
        tick(); intr_pending = 0;
        trap_seq("sint", 1, 20'h1234, 32'h80000005, 32'h0, 32'h120, 20'h214, 0);
        check("sint.priv", 32'(priv), 1);

        // SRET to U
        mstatus = 32'h20; sepc = 20'h300; s_ret = 1;
        tick(); s_ret = 0;
        ret_seq("sret", 1, 32'h22, 20'h300);
        check("sret.priv", 32'(priv), 0);

        // U-mode exception to M, with a new exception injected during SAVE_CAUSE
        medeleg = 0; mtvec = 20'h100; trap_PC = 20'h40; trap_value = 32'hDEADBEEF;
        mstatus = 32'h8; exception_code = 4'h8; exception = 1;
        tick(); exception = 0;
        trap_seq("uexc", 0, 20'h40, 32'h8, 32'hDEADBEEF, 32'h80, 20'h100, 1);
        check("uexc.priv", 32'(priv), 3);
        check("uexc.idle", 32'(busy), 0);

        // exception, interrupt and MRET together; interrupt held until IDLE
        medeleg = 16'hFFFF; mtvec = 20'h101; trap_PC = 20'h50; trap_value = 32'h77;
        mstatus = 0; exception_code = 4'h2; intr_code = 4'h7;
        exception = 1; intr_pending = 1; m_ret = 1;
        tick(); exception = 0; m_ret = 0;
        trap_seq("arb", 0, 20'h50, 32'h2, 32'h77, 32'h1800, 20'h100, 0);
        check("arb.priv", 32'(priv), 3);
        check("arb.idle", 32'(busy), 0);
        tick();
        check("pend.flush", 32'({busy, flush}), 32'h3);
        tick();
        check("pend.epc_en", 32'(csr_wr_en), 1);
        check("pend.epc_addr", 32'(csr_wr_addr), 32'h341);

        // reset during SAVE_EPC aborts the sequence
        intr_pending = 0; reset = 0;
        tick();
        check("abort.ctl", 32'({busy, flush, csr_wr_en, redirect_valid}), 0);
        check("abort.priv", 32'(priv), 3);
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort.quiet", 32'({busy, csr_wr_en, redirect_valid}), 0);
        end

        // vectored M interrupt whose target wraps the address width
        mtvec = 20'hFFFFD; mstatus = 32'h8; trap_PC = 20'h10; trap_value = 32'h99;
        intr_code = 4'hF; intr_pending = 1;
        tick(); intr_pending = 0;
        trap_seq("wrap", 0, 20'h10, 32'h8000000F, 32'h0, 32'h1880, 20'h00038, 0);
        check("wrap.priv", 32'(priv), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
